// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CHECK,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  localparam int LEN_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus IMEM write port, grouped as one bus.
// The loader uses the slave modport; the host/memory side uses master.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream. The word output
// is combinational so the loader can register it together with the address.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx;
  logic [23:0] sh;

  assign word       = {din, sh};
  assign word_valid = push && (idx == 2'(BYTES_PER_WORD - 1));

  // Byte index and the three lower bytes of the word in progress.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx <= '0;
      sh  <= '0;
    end else if (push) begin
      idx <= idx + 2'd1;
      sh  <= {din, sh[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked program frame, writes
// it into IMEM word by word and keeps the core in reset until it checks out.
//
// state   | meaning
// S_LEN   | collecting the 4 little-endian length bytes
// S_DATA  | collecting data bytes, one IMEM write per completed word
// S_CHECK | waiting for the XOR checksum byte
// S_HOLD  | checksum good, core_rst held for RST_HOLD more cycles
// S_RUN   | core released, IMEM untouched until reload
// S_ERR   | bad length or checksum, core held in reset until reload
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reload,
  imem_loader_if.slave    bus,
  output logic            core_rst,
  output logic            load_done,
  output logic            load_err,
  output logic [ADDR_W:0] word_count
);

  localparam int          HW        = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_W);

  state_t            state, state_nx;
  logic              ready;
  logic              accept, restart, len_last, pk_push, pk_valid;
  logic [31:0]       pk_word, len_full;
  logic [1:0]        len_idx;
  logic [23:0]       len_lo;
  logic [ADDR_W:0]   n_words, wc_q, wc_inc;
  logic [7:0]        xacc;
  logic [HW-1:0]     hold_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  assign accept   = bus.in_valid && ready;
  assign restart  = reload && ((state == S_RUN) || (state == S_ERR));
  assign len_full = {bus.in_data, len_lo};
  assign len_last = accept && (state == S_LEN) && (len_idx == 2'(LEN_BYTES - 1));
  assign pk_push  = accept && (state == S_DATA);
  assign wc_inc   = wc_q + (ADDR_W + 1)'(1);

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign word_count     = wc_q;

  byte_packer u_packer (
    .clk        (clk),
    .clr        (rst || restart),
    .push       (pk_push),
    .din        (bus.in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN;
    else     state <= state_nx;
  end

  // Next-state and state-decoded outputs. The last word moves us to S_CHECK
  // on the same edge its strobe is registered, so a checksum byte arriving
  // right behind it is accepted without a stall.
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    core_rst  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_LEN: begin
        ready = 1'b1;
        if (len_last) begin
          if (len_full == '0)            state_nx = S_CHECK;
          else if (len_full > MAX_WORDS) state_nx = S_ERR;
          else                           state_nx = S_DATA;
        end
      end
      S_DATA: begin
        ready = 1'b1;
        if (pk_valid && (wc_inc == n_words)) state_nx = S_CHECK;
      end
      S_CHECK: begin
        ready = 1'b1;
        if (accept) state_nx = (bus.in_data == xacc) ? S_HOLD : S_ERR;
      end
      S_HOLD: begin
        if (hold_cnt == '0) state_nx = S_RUN;
      end
      S_RUN: begin
        core_rst  = 1'b0;
        load_done = 1'b1;
        if (reload) state_nx = S_LEN;
      end
      S_ERR: begin
        load_err = 1'b1;
        if (reload) state_nx = S_LEN;
      end
      default: state_nx = S_LEN;
    endcase
  end

  // Length capture, word counter, checksum accumulator and IMEM write strobe.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      len_idx <= '0;
      len_lo  <= '0;
      n_words <= '0;
      wc_q    <= '0;
      xacc    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept && (state == S_LEN)) begin
        len_idx <= len_idx + 2'd1;
        len_lo  <= {bus.in_data, len_lo[23:8]};
        if (len_last) n_words <= len_full[ADDR_W:0];
      end
      if (pk_push) xacc <= xacc ^ bus.in_data;
      if (pk_valid) begin
        we_q    <= 1'b1;
        addr_q  <= wc_q[ADDR_W-1:0];
        wdata_q <= pk_word;
        wc_q    <= wc_inc;
      end
    end
  end

  // Post-checksum reset hold timer, a down-counter loaded on entry to S_HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((state == S_CHECK) && (state_nx == S_HOLD)) begin
      hold_cnt <= HW'(RST_HOLD);
    end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

endmodule
